// File: rtl/led_id_indicator.sv
// led_id_indicator: board-status LED driver with per-LED PWM level display and a heartbeat.
// Define LED_ID_BLINKCODE_EN to compile in the blink-code mode that flashes the board ID.
module led_id_indicator #(
    parameter int NUM_LED   = 5,
    parameter int PWM_BITS  = 2,
    parameter int ID_BITS   = 4,
    parameter int BEAT_BITS = 23,
    parameter int PWM_SHIFT = 17
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [ID_BITS-1:0]          id_in,
    input  logic [NUM_LED*PWM_BITS-1:0] level_in,
    input  logic                        mode_in,
    output logic [NUM_LED-1:0]          led_out,
    output logic                        beat_out,
    output logic                        code_busy
);

    logic [BEAT_BITS-1:0]        r_cnt;
    logic [NUM_LED*PWM_BITS-1:0] r_level_q;
    logic [NUM_LED-1:0]          r_led;
    logic                        r_beat;

    logic                        w_phase;
    logic [PWM_BITS-1:0]         w_pwm;
    logic [NUM_LED-1:0]          w_display;
    logic                        w_blinkActive;
    logic [NUM_LED-1:0]          w_blinkLed;

    assign w_phase = r_cnt[BEAT_BITS-1];
    assign w_pwm   = r_cnt[PWM_SHIFT +: PWM_BITS];

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt     <= '0;
            r_level_q <= '0;
            r_beat    <= 1'b0;
        end else begin
            r_cnt     <= r_cnt + BEAT_BITS'(1);
            r_level_q <= level_in;
            r_beat    <= w_phase;
        end
    end

    // Each LED is lit for the first level_q[i] PWM slots of the on-half of the heartbeat.
    always_comb begin
        w_display = '0;
        for (int i = 0; i < NUM_LED; i++) begin
            w_display[i] = w_phase & (w_pwm < r_level_q[i*PWM_BITS +: PWM_BITS]);
        end
    end

`ifdef LED_ID_BLINKCODE_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    localparam logic [BEAT_BITS-1:0] QUARTER_LAST = {2'b00, {(BEAT_BITS-2){1'b1}}};
    localparam logic [BEAT_BITS-1:0] GAP_LAST     = {BEAT_BITS{1'b1}};

    state_t               r_state;
    state_t               w_nextState;
    logic [BEAT_BITS-1:0] r_tmr;
    logic [BEAT_BITS-1:0] w_nextTmr;
    logic [ID_BITS-1:0]   r_id_q;
    logic [ID_BITS-1:0]   r_rem;
    logic [ID_BITS-1:0]   w_nextRem;
    logic                 r_mode_q;
    logic                 r_busy;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= ST_IDLE;
            r_tmr    <= '0;
            r_rem    <= '0;
            r_id_q   <= '0;
            r_mode_q <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_nextState;
            r_tmr    <= w_nextTmr;
            r_rem    <= w_nextRem;
            r_id_q   <= id_in;
            r_mode_q <= mode_in;
            r_busy   <= (w_nextState != ST_IDLE);
        end
    end

    // The ID is sampled only in IDLE, so a code in flight always finishes with its original count.
    always_comb begin
        w_nextState = r_state;
        w_nextTmr   = r_tmr + BEAT_BITS'(1);
        w_nextRem   = r_rem;
        case (r_state)
            ST_IDLE: begin
                w_nextTmr = '0;
                if (r_mode_q) begin
                    w_nextRem   = r_id_q;
                    w_nextState = (r_id_q != '0) ? ST_ON : ST_GAP;
                end
            end
            ST_ON: begin
                if (r_tmr == QUARTER_LAST) begin
                    w_nextTmr   = '0;
                    w_nextState = ST_OFF;
                end
            end
            ST_OFF: begin
                if (r_tmr == QUARTER_LAST) begin
                    w_nextTmr   = '0;
                    w_nextRem   = r_rem - ID_BITS'(1);
                    w_nextState = (r_rem == ID_BITS'(1)) ? ST_GAP : ST_ON;
                end
            end
            ST_GAP: begin
                if (r_tmr == GAP_LAST) begin
                    w_nextTmr   = '0;
                    w_nextState = ST_IDLE;
                end
            end
            default: begin
                w_nextTmr   = '0;
                w_nextState = ST_IDLE;
            end
        endcase
        if ((r_state != ST_IDLE) && !r_mode_q) begin
            w_nextTmr   = '0;
            w_nextState = ST_IDLE;
        end
    end

    assign w_blinkActive = r_mode_q;
    assign w_blinkLed    = {NUM_LED{r_state == ST_ON}};
    assign code_busy     = r_busy;
`else
    logic w_unused;

    assign w_unused      = ^{id_in, mode_in};
    assign w_blinkActive = 1'b0;
    assign w_blinkLed    = '0;
    assign code_busy     = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_led <= '0;
        end else if (w_blinkActive) begin
            r_led <= w_blinkLed;
        end else begin
            r_led <= w_display;
        end
    end

    assign led_out  = r_led;
    assign beat_out = r_beat;

endmodule

// File: tb/tb_led_id_indicator.sv
// Testbench for led_id_indicator: scoreboard of expected counts and latencies, checked as the DUT runs.
// Blink-code scenarios are exercised when LED_ID_BLINKCODE_EN is defined, otherwise mode_in must be ignored.
`timescale 1ns/1ps
module tb_led_id_indicator;

    localparam int NUM_LED   = 3;
    localparam int PWM_BITS  = 2;
    localparam int ID_BITS   = 4;
    localparam int BEAT_BITS = 6;
    localparam int PWM_SHIFT = 1;
    localparam int LW        = NUM_LED * PWM_BITS;
    localparam logic [NUM_LED-1:0] ALL_ON = '1;

    logic               CLK = 1'b0;
    logic               RST;
    logic [ID_BITS-1:0] id_in;
    logic [LW-1:0]      level_in;
    logic               mode_in;
    logic [NUM_LED-1:0] led_out;
    logic               beat_out;
    logic               code_busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string tag;
        int    value;
    } expect_t;
    expect_t sbQueue[$];

    int mPulses, mOn, mBad, mMinW, mMaxW, mW, mChangeAt;
    logic mPrevOn;
    logic [ID_BITS-1:0] mNewId;

    led_id_indicator #(
        .NUM_LED  (NUM_LED),
        .PWM_BITS (PWM_BITS),
        .ID_BITS  (ID_BITS),
        .BEAT_BITS(BEAT_BITS),
        .PWM_SHIFT(PWM_SHIFT)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .id_in    (id_in),
        .level_in (level_in),
        .mode_in  (mode_in),
        .led_out  (led_out),
        .beat_out (beat_out),
        .code_busy(code_busy)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic pushExpect(input string tag, input int value);
        expect_t e;
        e.tag   = tag;
        e.value = value;
        sbQueue.push_back(e);
    endtask

    task automatic popCheck(input int observed);
        expect_t e;
        if (sbQueue.size() == 0) begin
            checkOutput("scoreboard_empty", sbQueue.size(), 1);
            return;
        end
        e = sbQueue.pop_front();
        checkOutput(e.tag, observed, e.value);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input logic rst, input logic [ID_BITS-1:0] id,
                                 input logic [LW-1:0] level, input logic mode);
        RST      = rst;
        id_in    = id;
        level_in = level;
        mode_in  = mode;
    endtask

    task automatic waitBusyRise(output int n);
        n = 0;
        for (int i = 0; i < 500; i++) begin
            tick();
            n++;
            if (code_busy) break;
        end
    endtask

    task automatic sampleLed();
        if (led_out != '0 && led_out != ALL_ON) mBad++;
        if (led_out[0]) begin
            mOn++;
            mW++;
            if (!mPrevOn) begin
                mPulses++;
                if (mPulses == mChangeAt) id_in = mNewId;
            end
        end else if (mPrevOn) begin
            if (mW < mMinW) mMinW = mW;
            if (mW > mMaxW) mMaxW = mW;
            mW = 0;
        end
        mPrevOn = led_out[0];
    endtask

    // Entered on the first sample with code_busy high; leaves on the first high sample of the next code.
    task automatic measureCode(input int changeAt, input logic [ID_BITS-1:0] newId,
                               output int busyLen, output int lowLen);
        mPulses = 0; mOn = 0; mBad = 0; mMinW = 1000; mMaxW = 0; mW = 0; mPrevOn = 1'b0;
        mChangeAt = changeAt;
        mNewId    = newId;
        busyLen   = 0;
        lowLen    = 0;
        for (int i = 0; i < 4000 && code_busy; i++) begin
            sampleLed();
            busyLen++;
            tick();
        end
        sampleLed();
        for (int i = 0; i < 400 && !code_busy; i++) begin
            lowLen++;
            tick();
        end
    endtask

    task automatic expectCode(input string name, input int k);
        pushExpect({name, "_busy_len"}, 32 * k + 64);
        pushExpect({name, "_pulses"}, k);
        pushExpect({name, "_on_samples"}, 16 * k);
        pushExpect({name, "_mixed_leds"}, 0);
        pushExpect({name, "_idle_len"}, 1);
        if (k > 0) begin
            pushExpect({name, "_min_width"}, 16);
            pushExpect({name, "_max_width"}, 16);
        end
    endtask

    task automatic checkCode(input int k, input int busyLen, input int lowLen);
        popCheck(busyLen);
        popCheck(mPulses);
        popCheck(mOn);
        popCheck(mBad);
        popCheck(lowLen);
        if (k > 0) begin
            popCheck(mMinW);
            popCheck(mMaxW);
        end
    endtask

    task automatic countDisplay(input int n, output int c0, output int c1, output int c2,
                                output int busyHigh);
        c0 = 0; c1 = 0; c2 = 0; busyHigh = 0;
        for (int i = 0; i < n; i++) begin
            c0 += int'(led_out[0]);
            c1 += int'(led_out[1]);
            c2 += int'(led_out[2]);
            busyHigh += int'(code_busy);
            tick();
        end
    endtask

    initial begin
        int nz, firstRise, mism, toggles, ph0On, c0, c1, c2, bh, lat, bl, ll;
        logic prevBeat;
        logic [LW-1:0] lvl1, lvl2;

        lvl1 = {2'd1, 2'd0, 2'd3};
        lvl2 = {2'd1, 2'd3, 2'd3};

        // Reset with random inputs.
        applyStimulus(1'b1, ID_BITS'($urandom), LW'($urandom), 1'($urandom));
        pushExpect("reset_nonzero_samples", 0);
        nz = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (led_out != '0 || beat_out || code_busy) nz++;
            applyStimulus(1'b1, ID_BITS'($urandom), LW'($urandom), 1'($urandom));
        end
        popCheck(nz);

        // Display mode: levels LED0=3, LED1=0, LED2=1.
        applyStimulus(1'b0, 4'd3, lvl1, 1'b0);
        pushExpect("beat_first_rise", 32);
        pushExpect("disp_led0_phase1", 24);
        pushExpect("disp_led1_phase1", 0);
        pushExpect("disp_led2_phase1", 8);
        pushExpect("disp_phase0_lit", 0);
        pushExpect("beat_mismatch", 0);
        pushExpect("beat_toggles", 3);
        firstRise = -1; mism = 0; toggles = 0; ph0On = 0; c0 = 0; c1 = 0; c2 = 0;
        prevBeat = beat_out;
        for (int k = 0; k < 128; k++) begin
            logic eb;
            tick();
            eb = ((k % 64) >= 32);
            if (beat_out !== eb) mism++;
            if (beat_out !== prevBeat) toggles++;
            prevBeat = beat_out;
            if (beat_out && firstRise < 0) firstRise = k;
            if (k >= 32 && k < 64) begin
                c0 += int'(led_out[0]);
                c1 += int'(led_out[1]);
                c2 += int'(led_out[2]);
            end
            if (!eb && led_out != '0) ph0On++;
        end
        popCheck(firstRise);
        popCheck(c0);
        popCheck(c1);
        popCheck(c2);
        popCheck(ph0On);
        popCheck(mism);
        popCheck(toggles);

        // level_in to led_out latency, measured at the start of an on-half.
        for (int k = 128; k < 160; k++) tick();
        applyStimulus(1'b0, 4'd3, lvl2, 1'b0);
        pushExpect("level_latency_edge1", 0);
        pushExpect("level_latency_edge2", 1);
        tick();
        popCheck(led_out[1]);
        tick();
        popCheck(led_out[1]);

`ifdef LED_ID_BLINKCODE_EN
        // Blink code for ID 3, then ID change 3->5 during the second burst.
        pushExpect("mode_rise_latency", 2);
        applyStimulus(1'b0, 4'd3, lvl2, 1'b1);
        waitBusyRise(lat);
        popCheck(lat);
        expectCode("code1_id3", 3);
        measureCode(0, 4'd0, bl, ll);
        checkCode(3, bl, ll);
        expectCode("code2_id3", 3);
        measureCode(2, 4'd5, bl, ll);
        checkCode(3, bl, ll);
        expectCode("code3_id5", 5);
        measureCode(0, 4'd0, bl, ll);
        checkCode(5, bl, ll);

        // mode_in drops during ON.
        for (int i = 0; i < 100 && !led_out[0]; i++) tick();
        repeat (3) tick();
        pushExpect("drop_busy_edge1", 1);
        pushExpect("drop_led_edge1", 7);
        pushExpect("drop_busy_edge2", 0);
        applyStimulus(1'b0, 4'd5, lvl2, 1'b0);
        tick();
        popCheck(code_busy);
        popCheck(led_out);
        tick();
        popCheck(code_busy);
        pushExpect("resume_led0", 24);
        pushExpect("resume_led1", 24);
        pushExpect("resume_led2", 8);
        pushExpect("resume_busy", 0);
        countDisplay(64, c0, c1, c2, bh);
        popCheck(c0);
        popCheck(c1);
        popCheck(c2);
        popCheck(bh);

        // RST for one cycle during OFF, then a fresh code.
        applyStimulus(1'b0, 4'd5, lvl2, 1'b1);
        waitBusyRise(lat);
        for (int i = 0; i < 100 && !led_out[0]; i++) tick();
        for (int i = 0; i < 100 && led_out[0]; i++) tick();
        repeat (4) tick();
        pushExpect("midrst_led", 0);
        pushExpect("midrst_beat", 0);
        pushExpect("midrst_busy", 0);
        applyStimulus(1'b1, 4'd5, lvl2, 1'b1);
        tick();
        popCheck(led_out);
        popCheck(beat_out);
        popCheck(code_busy);
        pushExpect("release_busy_latency", 2);
        applyStimulus(1'b0, 4'd5, lvl2, 1'b1);
        waitBusyRise(lat);
        popCheck(lat);
        applyStimulus(1'b0, 4'd0, lvl2, 1'b1);
        expectCode("fresh_id5", 5);
        expectCode("code_id0", 0);
        measureCode(0, 4'd0, bl, ll);
        checkCode(5, bl, ll);
        measureCode(0, 4'd0, bl, ll);
        checkCode(0, bl, ll);
`else
        // Without the blink-code feature mode_in is ignored.
        applyStimulus(1'b0, 4'd3, lvl2, 1'b1);
        pushExpect("nomacro_led0", 24);
        pushExpect("nomacro_led1", 24);
        pushExpect("nomacro_led2", 8);
        pushExpect("nomacro_busy", 0);
        countDisplay(64, c0, c1, c2, bh);
        popCheck(c0);
        popCheck(c1);
        popCheck(c2);
        popCheck(bh);
        pushExpect("nomacro_rst_led", 0);
        pushExpect("nomacro_rst_beat", 0);
        pushExpect("nomacro_rst_busy", 0);
        applyStimulus(1'b1, 4'd3, lvl2, 1'b1);
        tick();
        popCheck(led_out);
        popCheck(beat_out);
        popCheck(code_busy);
        applyStimulus(1'b0, 4'd3, lvl2, 1'b1);
        pushExpect("nomacro_beat_rise", 32);
        pushExpect("nomacro_busy_after", 0);
        firstRise = -1;
        bh = 0;
        for (int k = 0; k < 64; k++) begin
            tick();
            if (beat_out && firstRise < 0) firstRise = k;
            bh += int'(code_busy);
        end
        popCheck(firstRise);
        popCheck(bh);
`endif

        checkOutput("scoreboard_leftover", sbQueue.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
